puf_challenge_sweeper: RTL
==========================

PUF_CHALLENGE_SWEEPER -- requirements
Module: puf_challenge_sweeper

Interface
REQ-001 Parameter NUM_EVAL, default 5, meaning evaluations per challenge; SHALL be odd, 1..7.
REQ-002 Parameter TIMEOUT_CYC, default 2^29, meaning max clk cycles allowed waiting for puf_done per evaluation.
REQ-003 Parameter RST_CYC, default 2, meaning puf_rst pulse length in cycles.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  global clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 start  input  1  single-cycle request to sweep challenges 0..63.
REQ-008 challenge  output  6  challenge driven to the PUF core.
REQ-009 puf_rst  output  1  reset to the PUF core FSM.
REQ-010 puf_en  output  1  enable to the PUF core ring oscillators and FSM.
REQ-011 puf_done  input  1  PUF core done level.
REQ-012 puf_response  input  8  PUF core response, valid while puf_done=1.
REQ-013 busy  output  1  sweep in progress.
REQ-014 sweep_done  output  1  one-cycle pulse when the sweep completes.
REQ-015 timeout_err  output  1  sticky error flag.
REQ-016 rd_addr  input  6  readout challenge index.
REQ-017 rd_data  output  8  majority response for rd_addr.
REQ-018 rd_unstable  output  1  any bit of rd_addr's evaluations disagreed.
REQ-019 rd_valid  output  1  entry rd_addr written in the current sweep.

Function
REQ-020 States SHALL be IDLE, PRST, EVAL, ACCUM, STORE, DONE, ERR.
REQ-021 IDLE: start=1 -> PRST; clear valid[63:0], chal_idx=0, eval_cnt=0, all per-bit ones counters=0, timeout_err=0.
REQ-022 challenge SHALL equal chal_idx in every state.
REQ-023 PRST: puf_rst=1, puf_en=0, for exactly RST_CYC cycles -> EVAL; wait counter cleared on entry.
REQ-024 EVAL: puf_en=1, wait counter increments each cycle; puf_done=1 -> ACCUM; wait counter reaching TIMEOUT_CYC-1 with puf_done=0 -> ERR.
REQ-025 ACCUM (one cycle): for each bit b, ones[b] += puf_response[b] (sampled on the EVAL->ACCUM edge); eval_cnt += 1; puf_en=1; eval_cnt == NUM_EVAL-1 -> STORE else -> PRST.
REQ-026 STORE (one cycle): table[chal_idx] = {unstable, maj[7:0]}, maj[b] = (ones[b] > NUM_EVAL/2), unstable = OR over b of (ones[b] != 0 && ones[b] != NUM_EVAL); valid[chal_idx]=1; ones, eval_cnt cleared.
REQ-027 STORE: chal_idx == 63 -> DONE; else chal_idx += 1 -> PRST.
REQ-028 DONE (one cycle): sweep_done=1 -> IDLE; chal_idx SHALL NOT wrap into a second sweep.
REQ-029 ERR: timeout_err=1, puf_en=0, puf_rst=1; stays until rst or start; start -> clears and begins new sweep as in REQ-021.
REQ-030 busy=1 in PRST, EVAL, ACCUM, STORE; 0 otherwise.
REQ-031 start while busy=1 SHALL be ignored.
REQ-032 ones[b] width 3 bits; wait counter width clog2(TIMEOUT_CYC); no overflow possible within parameter limits.
REQ-033 Readout: rd_data, rd_unstable, rd_valid registered, 1-cycle latency from rd_addr; read during a same-cycle STORE to the same index returns the old contents.
REQ-034 puf_done dropping during EVAL before sampling SHALL be treated as not done.

Reset
REQ-035 rst=1 SHALL force IDLE, challenge=0, puf_rst=1, puf_en=0, busy=0, sweep_done=0, timeout_err=0, rd_data=0, rd_unstable=0, rd_valid=0, valid[63:0]=0, all counters 0.
REQ-036 rst mid-sweep SHALL abandon the sweep; table contents need not be cleared, but all valid bits SHALL read 0.

Verification
REQ-037 PUF model done 10 cycles after puf_en, response = challenge ^ 8'hA5, NUM_EVAL=5; start -> sweep_done after 64 entries; rd_addr=3 -> rd_data=8'hA6, rd_unstable=0, rd_valid=1.
REQ-038 Model flips bit 0 in 2 of 5 evaluations of challenge 7 -> rd_data[0] equals the majority value, rd_unstable=1 for index 7, 0 for index 6.
REQ-039 Model never asserts done, TIMEOUT_CYC=100 -> ERR after 100 EVAL cycles, timeout_err=1, busy=0, puf_en=0; next start clears timeout_err.
REQ-040 rst asserted during challenge 20 -> next cycle IDLE, busy=0, rd_valid=0 for index 0.
REQ-041 start pulsed while busy -> sweep unaffected, exactly one sweep_done pulse.
REQ-042 Check puf_rst high exactly RST_CYC cycles before each evaluation, 64*NUM_EVAL=320 evaluations total.

Source files
------------

// File: rtl/puf_challenge_sweeper.sv
// Sweeps PUF challenges 0..63, evaluating each NUM_EVAL times and storing the majority response plus a stability flag.
// Readout has one cycle of latency. There is no backpressure: start is accepted only in IDLE or ERR and is ignored while busy.
module puf_challenge_sweeper #(
  parameter int NUM_EVAL    = 5,
  parameter int TIMEOUT_CYC = 2**29,
  parameter int RST_CYC     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [5:0] challenge,
  output logic       puf_rst,
  output logic       puf_en,
  input  logic       puf_done,
  input  logic [7:0] puf_response,
  output logic       busy,
  output logic       sweep_done,
  output logic       timeout_err,
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       rd_unstable,
  output logic       rd_valid
);

  // The wait counter is shared by the PRST pulse and the EVAL timeout, so it is sized for the larger of the two.
  localparam int CNT_MAX = (TIMEOUT_CYC > RST_CYC) ? TIMEOUT_CYC : RST_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYC - 1);
  localparam logic [2:0]       EVAL_LAST = 3'(NUM_EVAL - 1);
  localparam logic [2:0]       HALF      = 3'(NUM_EVAL / 2);
  localparam logic [2:0]       N_EVAL    = 3'(NUM_EVAL);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRST  = 3'd1,
    EVAL  = 3'd2,
    ACCUM = 3'd3,
    STORE = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       chal_idx_q, chal_idx_d;
  logic [2:0]       eval_cnt_q, eval_cnt_d;
  logic [7:0][2:0]  ones_q, ones_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       resp_q, resp_d;
  logic [63:0]      valid_q, valid_d;
  logic             timeout_err_q, timeout_err_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_unstable_q, rd_unstable_d;
  logic             rd_valid_q, rd_valid_d;

  // Each entry holds {unstable, majority[7:0]}; no reset, validity lives in valid_q.
  logic [8:0]       tbl_q [64];
  logic             tbl_we;
  logic [7:0]       maj;
  logic             unstable;

  always_comb begin
    maj      = '0;
    unstable = 1'b0;
    for (int b = 0; b < 8; b++) begin
      maj[b] = (ones_q[b] > HALF);
      if ((ones_q[b] != 3'd0) && (ones_q[b] != N_EVAL)) unstable = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    chal_idx_d    = chal_idx_q;
    eval_cnt_d    = eval_cnt_q;
    ones_d        = ones_q;
    cnt_d         = cnt_q;
    resp_d        = resp_q;
    valid_d       = valid_q;
    timeout_err_d = timeout_err_q;
    tbl_we        = 1'b0;
    case (state_q)
      IDLE, ERR: begin
        if (start) begin
          state_d       = PRST;
          valid_d       = '0;
          chal_idx_d    = '0;
          eval_cnt_d    = '0;
          ones_d        = '0;
          cnt_d         = '0;
          timeout_err_d = 1'b0;
        end
      end
      PRST: begin
        if (cnt_q == RST_LAST) begin
          state_d = EVAL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EVAL: begin
        // Only a done level present at the sampling edge counts; earlier glitches are ignored.
        if (puf_done) begin
          state_d = ACCUM;
          resp_d  = puf_response;
        end else if (cnt_q == TO_LAST) begin
          state_d       = ERR;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACCUM: begin
        for (int b = 0; b < 8; b++) ones_d[b] = ones_q[b] + {2'b00, resp_q[b]};
        eval_cnt_d = eval_cnt_q + 1'b1;
        if (eval_cnt_q == EVAL_LAST) begin
          state_d = STORE;
        end else begin
          state_d = PRST;
          cnt_d   = '0;
        end
      end
      STORE: begin
        tbl_we              = 1'b1;
        valid_d[chal_idx_q] = 1'b1;
        ones_d              = '0;
        eval_cnt_d          = '0;
        if (chal_idx_q == 6'd63) begin
          state_d = DONE;
        end else begin
          chal_idx_d = chal_idx_q + 1'b1;
          state_d    = PRST;
          cnt_d      = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_data_d     = tbl_q[rd_addr][7:0];
    rd_unstable_d = tbl_q[rd_addr][8];
    rd_valid_d    = valid_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      chal_idx_q    <= '0;
      eval_cnt_q    <= '0;
      ones_q        <= '0;
      cnt_q         <= '0;
      resp_q        <= '0;
      valid_q       <= '0;
      timeout_err_q <= 1'b0;
      rd_data_q     <= '0;
      rd_unstable_q <= 1'b0;
      rd_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      chal_idx_q    <= chal_idx_d;
      eval_cnt_q    <= eval_cnt_d;
      ones_q        <= ones_d;
      cnt_q         <= cnt_d;
      resp_q        <= resp_d;
      valid_q       <= valid_d;
      timeout_err_q <= timeout_err_d;
      rd_data_q     <= rd_data_d;
      rd_unstable_q <= rd_unstable_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tbl_we) tbl_q[chal_idx_q] <= {unstable, maj};
  end

  // The PUF core is held in reset whenever it is not actively evaluating.
  assign puf_rst     = (state_q == IDLE) || (state_q == PRST) || (state_q == DONE) || (state_q == ERR);
  assign puf_en      = (state_q == EVAL) || (state_q == ACCUM);
  assign busy        = (state_q == PRST) || (state_q == EVAL) || (state_q == ACCUM) || (state_q == STORE);
  assign sweep_done  = (state_q == DONE);
  assign challenge   = chal_idx_q;
  assign timeout_err = timeout_err_q;
  assign rd_data     = rd_data_q;
  assign rd_unstable = rd_unstable_q;
  assign rd_valid    = rd_valid_q;

endmodule
